// File: rtl/ypc_pkg.sv
// Shared types and constants for the YPC core's fetch front end.
package ypc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } ifu_state_e;

  // Instruction addresses are always word aligned; the two low bits are cleared.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_unit_if.sv
// Instruction-memory request/response port and the decode-facing
// instruction port of the fetch unit, bundled together.
interface ifu_fetch_unit_if;
  import ypc_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

endinterface

// File: rtl/ifu_inst_fifo.sv
// Small instruction buffer between fetch and decode. Flush wins over
// push and pop; simultaneous push and pop are accepted at any fill level.
module ifu_inst_fifo
  import ypc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset because occupancy guards them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_fetch_unit.sv
// YPC instruction fetch stage: owns the PC, keeps at most one instruction
// memory request in flight, buffers returned words for decode and handles
// redirects and halt. Optional feature macro: IFU_ALIGN_CHECK_EN adds a
// sticky misalign output that permanently stops fetching.
module ifu_fetch_unit
  import ypc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  ifu_fetch_unit_if.master  fetch_if,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH+1);

  ifu_state_e       state;
  ifu_state_e       state_next;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_next;
  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  req_pc_next;
  logic             drop;
  logic             drop_next;
  logic             req_valid;
  logic             push;
  logic             pop;
  logic             fetch_stop;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     rsp_entry;

`ifdef IFU_ALIGN_CHECK_EN
  // A misaligned redirect target latches an error that only reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end

  assign fetch_stop = halt || misalign;
`else
  assign fetch_stop = halt;
`endif

  assign rsp_entry = '{inst: fetch_if.imem_rsp_data, pc: req_pc};

  ifu_inst_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign fetch_if.inst_valid     = !reset && (fifo_count != '0);
  assign fetch_if.inst           = fifo_head.inst;
  assign fetch_if.inst_pc        = fifo_head.pc;
  assign pop                     = fetch_if.inst_valid && fetch_if.inst_ready;
  assign fetch_if.imem_req_valid = req_valid;
  assign fetch_if.imem_req_addr  = pc;

  // State, PC and drop flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      drop   <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      req_pc <= req_pc_next;
      drop   <= drop_next;
    end
  end

  // Request issue, response capture and redirect handling.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    drop_next   = drop;
    req_valid   = 1'b0;
    push        = 1'b0;

    case (state)
      FETCH: begin
        req_valid = !reset && !fetch_stop && !redirect_valid &&
                    (fifo_count < CNT_W'(BUF_DEPTH));
        if (req_valid && fetch_if.imem_req_ready) begin
          req_pc_next = pc;
          pc_next     = pc + 32'd4;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (fetch_if.imem_rsp_valid) begin
          state_next = FETCH;
          if (drop) begin
            drop_next = 1'b0;
          end else begin
            push = 1'b1;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = FETCH;
    endcase

    if (redirect_valid) begin
      pc_next = word_align(redirect_pc);
    end
  end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed bench for ifu_fetch_unit with a queue-based reference model.
module tb_ifu_fetch_unit;
  import ypc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
  logic        misalign;
`endif

  ifu_fetch_unit_if bus_if();

  ifu_fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_if       (bus_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .misalign       (misalign)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] acc_q[$];
  logic [31:0] dlv_q[$];

  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_req_pc = RST_PC;
  logic        m_busy = 1'b0;
  logic        m_drop = 1'b0;
  logic        m_mis = 1'b0;
  logic [63:0] m_q[$];

  // Memory contents as seen by the fetch unit: a fixed function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; also records handshakes seen in that cycle.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic rspv,
                               input logic [31:0] rspd, input logic irdy,
                               input logic redv, input logic [31:0] rpc,
                               input logic hlt);
    @(negedge clk);
    reset                 = rst;
    bus_if.imem_req_ready = rdy;
    bus_if.imem_rsp_valid = rspv;
    bus_if.imem_rsp_data  = rspd;
    bus_if.inst_ready     = irdy;
    redirect_valid        = redv;
    redirect_pc           = rpc;
    halt                  = hlt;
    #3;
    if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = bus_if.imem_req_addr;
      acc_q.push_back(bus_if.imem_req_addr);
    end else begin
      pend = 1'b0;
    end
    if (bus_if.inst_valid && bus_if.inst_ready) dlv_q.push_back(bus_if.inst_pc);
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    acc_q.delete();
    dlv_q.delete();
  endtask

  // Memory that answers one cycle after every accepted request.
  task automatic runAuto(input int n, input logic irdy, input logic hlt);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, pend, mem_word(pend_addr), irdy, 1'b0, '0, hlt);
    end
  endtask

  // Reference model: compare outputs each cycle, then advance one clock.
  initial begin : compare_proc
    logic exp_rv, exp_iv, stop, accept, popped, resp;
    forever begin
      @(negedge clk);
      #2;
      stop = halt;
`ifdef IFU_ALIGN_CHECK_EN
      stop = stop || m_mis;
`endif
      exp_rv = !reset && !m_busy && !stop && !redirect_valid && (m_q.size() < DEPTH);
      exp_iv = !reset && (m_q.size() != 0);
      checkOutput("req_valid", 32'(bus_if.imem_req_valid), 32'(exp_rv));
      if (exp_rv) checkOutput("req_addr", bus_if.imem_req_addr, m_pc);
      checkOutput("inst_valid", 32'(bus_if.inst_valid), 32'(exp_iv));
      if (exp_iv) begin
        checkOutput("inst", bus_if.inst, m_q[0][63:32]);
        checkOutput("inst_pc", bus_if.inst_pc, m_q[0][31:0]);
      end
`ifdef IFU_ALIGN_CHECK_EN
      checkOutput("misalign", 32'(misalign), 32'(m_mis));
`endif
      if (reset) begin
        m_pc   = RST_PC;
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_mis  = 1'b0;
        m_q.delete();
      end else begin
        accept = exp_rv && bus_if.imem_req_ready;
        popped = exp_iv && bus_if.inst_ready;
        resp   = m_busy && bus_if.imem_rsp_valid;
`ifdef IFU_ALIGN_CHECK_EN
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) m_mis = 1'b1;
`endif
        if (redirect_valid) begin
          m_q.delete();
          m_pc = {redirect_pc[31:2], 2'b00};
          if (resp) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
          end else if (m_busy) begin
            m_drop = 1'b1;
          end
        end else begin
          if (popped) void'(m_q.pop_front());
          if (resp) begin
            m_busy = 1'b0;
            if (m_drop) m_drop = 1'b0;
            else m_q.push_back({bus_if.imem_rsp_data, m_req_pc});
          end
          if (accept) begin
            m_busy   = 1'b1;
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = '0;
    bus_if.inst_ready     = 1'b0;

    $display("[TB] reset values");
    resetDut();
    checkOutput("rst_req_valid", 32'(bus_if.imem_req_valid), 32'h0);
    checkOutput("rst_inst_valid", 32'(bus_if.inst_valid), 32'h0);
    checkOutput("rst_req_addr", bus_if.imem_req_addr, 32'h8000_0000);
`ifdef IFU_ALIGN_CHECK_EN
    checkOutput("rst_misalign", 32'(misalign), 32'h0);
`endif

    $display("[TB] streaming fetch");
    runAuto(8, 1'b1, 1'b0);
    checkOutput("t1_num_req", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() == 4) begin
      checkOutput("t1_addr0", acc_q[0], 32'h8000_0000);
      checkOutput("t1_addr3", acc_q[3], 32'h8000_000C);
    end
    checkOutput("t1_num_dlv", 32'(dlv_q.size()), 32'd3);
    if (dlv_q.size() == 3) begin
      checkOutput("t1_dlv0", dlv_q[0], 32'h8000_0000);
      checkOutput("t1_dlv2", dlv_q[2], 32'h8000_0008);
    end

    $display("[TB] decode stall fills buffer");
    resetDut();
    runAuto(8, 1'b0, 1'b0);
    checkOutput("t2_num_req", 32'(acc_q.size()), 32'd2);
    checkOutput("t2_req_valid_full", 32'(bus_if.imem_req_valid), 32'h0);
    checkOutput("t2_head_pc", bus_if.inst_pc, 32'h8000_0000);
    runAuto(1, 1'b1, 1'b0);
    checkOutput("t2_req_valid_pop", 32'(bus_if.imem_req_valid), 32'h0);
    runAuto(1, 1'b0, 1'b0);
    checkOutput("t2_req_after_pop", 32'(bus_if.imem_req_valid), 32'h1);
    checkOutput("t2_addr_after_pop", bus_if.imem_req_addr, 32'h8000_0008);
    runAuto(4, 1'b0, 1'b0);
    checkOutput("t2_num_req_end", 32'(acc_q.size()), 32'd3);

    $display("[TB] redirect while waiting");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t3_wait_req_valid", 32'(bus_if.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t3_dropped_empty", 32'(bus_if.inst_valid), 32'h0);
    checkOutput("t3_new_addr", bus_if.imem_req_addr, 32'h8000_0100);
    applyStimulus(1'b0, 1'b0, 1'b1, mem_word(32'h8000_0100), 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t3_inst_pc", bus_if.inst_pc, 32'h8000_0100);
    checkOutput("t3_inst", bus_if.inst, 32'hDA5A_0113);

    $display("[TB] redirect with response and pop");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, mem_word(pend_addr), 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_second_addr", bus_if.imem_req_addr, 32'h8000_0004);
    applyStimulus(1'b0, 1'b1, 1'b1, mem_word(pend_addr), 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t4_flushed", 32'(bus_if.inst_valid), 32'h0);
    checkOutput("t4_redir_addr", bus_if.imem_req_addr, 32'h8000_0200);
    applyStimulus(1'b0, 1'b0, 1'b1, mem_word(pend_addr), 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_inst_pc", bus_if.inst_pc, 32'h8000_0200);

    $display("[TB] halt while waiting");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, mem_word(pend_addr), 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t5_halt_req", 32'(bus_if.imem_req_valid), 32'h0);
    checkOutput("t5_halt_inst_pc", bus_if.inst_pc, 32'h8000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t5_resume_req", 32'(bus_if.imem_req_valid), 32'h1);
    checkOutput("t5_resume_addr", bus_if.imem_req_addr, 32'h8000_0004);

    $display("[TB] reset with a request in flight");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t6_req_addr", bus_if.imem_req_addr, 32'h8000_0000);
    checkOutput("t6_empty", 32'(bus_if.inst_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, mem_word(32'h8000_0000), 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t6_inst", bus_if.inst, 32'hDA5A_0013);

    $display("[TB] pc wrap and low address bits");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checkOutput("t7_redir_no_req", 32'(bus_if.imem_req_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t7_top_addr", bus_if.imem_req_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b1, mem_word(pend_addr), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t7_wrap_addr", bus_if.imem_req_addr, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 1'b1, mem_word(pend_addr), 1'b1, 1'b1, 32'h8000_0102, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
`ifdef IFU_ALIGN_CHECK_EN
    checkOutput("t7_misalign", 32'(misalign), 32'h1);
    checkOutput("t7_mis_no_req", 32'(bus_if.imem_req_valid), 32'h0);
    runAuto(3, 1'b1, 1'b0);
    checkOutput("t7_mis_still_no_req", 32'(bus_if.imem_req_valid), 32'h0);
`else
    checkOutput("t7_masked_addr", bus_if.imem_req_addr, 32'h8000_0100);
    runAuto(3, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
